// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with parity/framing error flags,
// false-start reject, break recovery and a valid/ready output FIFO with a
// sticky overrun flag.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   -> each bit decision is a 2-of-3 majority of the last three
//                oversampled values, rejecting single-tick glitches.
//   undefined -> each bit decision is the single sample at the decision point.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  input  logic                 clr_ovr,
  output logic                 busy
);

  // Baud divider, rounded to the nearest integer
  localparam longint RATE    = longint'(BAUD) * longint'(OVERSAMPLE);
  localparam longint DIV_L   = (longint'(CLK_FREQ) + RATE / 2) / RATE;
  localparam longint ERR_L   = DIV_L * RATE - longint'(CLK_FREQ);
  localparam longint ERR_ABS = (ERR_L < 0) ? -ERR_L : ERR_L;
  localparam int     DIV     = int'(DIV_L);
  localparam int     DIV_W   = (DIV < 2) ? 1 : $clog2(DIV);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int W     = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] START_PT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_BITS - 1);

  // Reject configurations the receiver cannot sample reliably
  if (DIV < 2) begin : gDivTooSmall
    $error("uart_rx_fifo: baud divider below 2");
  end
  if (ERR_ABS * 50 > longint'(CLK_FREQ)) begin : gBaudError
    $error("uart_rx_fifo: baud rate error above 2 percent");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : gBadOversample
    $error("uart_rx_fifo: OVERSAMPLE must be a power of 2, at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rxState_t;

  rxState_t             state;
  logic [DIV_W-1:0]     tickCnt;
  logic                 tick;
  logic                 rxMeta;
  logic                 rxS;
  logic                 sampleBit;
  logic [CNT_W-1:0]     cnt;
  logic [BC_W-1:0]      bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 perrReg;
  logic                 pushReq;
  logic [W-1:0]         pushWord;

  logic [W-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]          wrPtr;
  logic [AW:0]          rdPtr;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 doWrite;
  logic [W-1:0]         headWord;

  assign tick = (tickCnt == '0);

  // Free-running oversample tick: one clk pulse every DIV clocks
  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt <= DIV_W'(DIV - 1);
    end else if (tick) begin
      tickCnt <= DIV_W'(DIV - 1);
    end else begin
      tickCnt <= tickCnt - 1'b1;
    end
  end

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rxd;
      rxS    <= rxMeta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rxHist;

  // Keep the two previous tick samples for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxHist <= 2'b11;
    end else if (tick) begin
      rxHist <= {rxHist[0], rxS};
    end
  end

  assign sampleBit = (rxHist[1] & rxHist[0]) | (rxHist[1] & rxS) | (rxHist[0] & rxS);
`else
  assign sampleBit = rxS;
`endif

  // Receiver FSM: bit timing, shifting, error flags and the push request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      perrReg  <= 1'b0;
      pushReq  <= 1'b0;
      pushWord <= '0;
      busy     <= 1'b0;
    end else begin
      pushReq <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (!rxS) begin
              state <= ST_START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          ST_START: begin
            if (cnt == START_PT) begin
              cnt <= '0;
              if (sampleBit) begin
                // Line went back high before mid-start: false start
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= ST_DATA;
                bitCnt  <= '0;
                perrReg <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt == BIT_PT) begin
              cnt      <= '0;
              shiftReg <= {sampleBit, shiftReg[DATA_BITS-1:1]};
              if (bitCnt == LAST_BIT) begin
                state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bitCnt <= bitCnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (cnt == BIT_PT) begin
              cnt     <= '0;
              perrReg <= ((^shiftReg) ^ sampleBit) != (PARITY == 1);
              state   <= ST_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt == BIT_PT) begin
              cnt      <= '0;
              pushReq  <= 1'b1;
              pushWord <= {~sampleBit, perrReg, shiftReg};
              if (sampleBit) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_BREAK: begin
            // Hold off until the line recovers so a long low is one entry
            if (rxS) begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop     = !empty && m_ready;
  assign doWrite = pushReq && (!full || pop);

  // Output FIFO storage and pointers
  // NOTE: the storage is reset on purpose: it is a tiny register file and the
  // head outputs are read straight from it, so they must be 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doWrite) begin
        mem[wrPtr[AW-1:0]] <= pushWord;
        wrPtr              <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  // Sticky overrun: a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (pushReq && full && !pop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  assign headWord = mem[rdPtr[AW-1:0]];
  assign m_data   = headWord[DATA_BITS-1:0];
  assign m_perr   = headWord[DATA_BITS];
  assign m_ferr   = headWord[DATA_BITS+1];
  assign m_valid  = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Two instances: an 8N1 receiver and an 8E1 receiver, both at
// CLK_FREQ=18432000, BAUD=115200, OVERSAMPLE=16 (DIV=10, 160 clks per bit).
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 160;
  localparam int WAIT_MAX = 3000;

  logic       clk;
  logic       rst_n;

  logic       rxd;
  logic [7:0] mData;
  logic       mPerr;
  logic       mFerr;
  logic       mValid;
  logic       mReady;
  logic       ovr;
  logic       clrOvr;
  logic       busy;

  logic       rxdP;
  logic [7:0] mDataP;
  logic       mPerrP;
  logic       mFerrP;
  logic       mValidP;
  logic       mReadyP;
  logic       ovrP;
  logic       clrOvrP;
  logic       busyP;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .CLK_FREQ(18432000), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .m_data(mData), .m_perr(mPerr), .m_ferr(mFerr),
    .m_valid(mValid), .m_ready(mReady),
    .overrun(ovr), .clr_ovr(clrOvr), .busy(busy)
  );

  uart_rx_fifo #(
    .CLK_FREQ(18432000), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
  ) dutPar (
    .clk(clk), .rst_n(rst_n), .rxd(rxdP),
    .m_data(mDataP), .m_perr(mPerrP), .m_ferr(mFerrP),
    .m_valid(mValidP), .m_ready(mReadyP),
    .overrun(ovrP), .clr_ovr(clrOvrP), .busy(busyP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setLine(input int sel, input logic b);
    if (sel == 0) rxd = b;
    else          rxdP = b;
  endtask

  task automatic driveBit(input int sel, input logic b);
    setLine(sel, b);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start, data LSB first, optional parity; returns at the start of the stop bit
  task automatic sendFrame(input int sel, input logic [7:0] d, input bit hasPar, input logic parBit);
    driveBit(sel, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(sel, d[i]);
    if (hasPar) driveBit(sel, parBit);
    setLine(sel, 1'b1);
  endtask

  // Returns on the first negedge where busy is low; bounded
  task automatic waitBusyFall(input int sel, input string tag);
    int n;
    logic b;
    n = 0;
    b = (sel == 0) ? busy : busyP;
    while (b && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
      b = (sel == 0) ? busy : busyP;
    end
    check({tag, "_busy_fall"}, 32'(!b), 32'd1);
  endtask

  task automatic popHead(input int sel);
    if (sel == 0) mReady = 1'b1;
    else          mReadyP = 1'b1;
    @(negedge clk);
    mReady  = 1'b0;
    mReadyP = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rxd     = 1'b1;
    rxdP    = 1'b1;
    mReady  = 1'b0;
    mReadyP = 1'b0;
    clrOvr  = 1'b0;
    clrOvrP = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_m_valid", 32'(mValid), 32'd0);
    check("rst_m_data",  32'(mData),  32'd0);
    check("rst_m_perr",  32'(mPerr),  32'd0);
    check("rst_m_ferr",  32'(mFerr),  32'd0);
    check("rst_overrun", 32'(ovr),    32'd0);
    check("rst_busy",    32'(busy),   32'd0);
    check("rst_p_valid", 32'(mValidP), 32'd0);
    rst_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);

    // 0xA5 with m_ready high: single m_valid pulse one clk after the stop decision
    mReady = 1'b1;
    sendFrame(0, 8'hA5, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("a5_busy_mid", 32'(busy), 32'd1);
    waitBusyFall(0, "a5");
    check("a5_valid_at_decision", 32'(mValid), 32'd0);
    @(negedge clk);
    check("a5_valid_next", 32'(mValid), 32'd1);
    check("a5_data", 32'(mData), 32'hA5);
    check("a5_perr", 32'(mPerr), 32'd0);
    check("a5_ferr", 32'(mFerr), 32'd0);
    @(negedge clk);
    check("a5_valid_pulse_end", 32'(mValid), 32'd0);
    mReady = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // Even parity: 0x03 has two ones, so parity bit 1 is an error, 0 is fine
    sendFrame(1, 8'h03, 1'b1, 1'b1);
    waitBusyFall(1, "par1");
    repeat (2) @(negedge clk);
    check("par1_valid", 32'(mValidP), 32'd1);
    check("par1_data",  32'(mDataP),  32'h03);
    check("par1_perr",  32'(mPerrP),  32'd1);
    check("par1_ferr",  32'(mFerrP),  32'd0);
    popHead(1);
    repeat (BIT_CLKS) @(negedge clk);
    sendFrame(1, 8'h03, 1'b1, 1'b0);
    waitBusyFall(1, "par0");
    repeat (2) @(negedge clk);
    check("par0_valid", 32'(mValidP), 32'd1);
    check("par0_data",  32'(mDataP),  32'h03);
    check("par0_perr",  32'(mPerrP),  32'd0);
    popHead(1);
    check("par0_drained", 32'(mValidP), 32'd0);

    // Overrun: five back-to-back frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      sendFrame(0, 8'(8'h10 + i), 1'b0, 1'b0);
      if (i < 4) repeat (BIT_CLKS) @(negedge clk);
    end
    waitBusyFall(0, "ovr_last");
    repeat (3) @(negedge clk);
    check("ovr_set",   32'(ovr),    32'd1);
    check("ovr_valid", 32'(mValid), 32'd1);
    check("ovr_head",  32'(mData),  32'h10);
    clrOvr = 1'b1;
    @(negedge clk);
    clrOvr = 1'b0;
    check("ovr_cleared", 32'(ovr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_entry%0d", i), 32'(mData), 32'h10 + 32'(i));
      popHead(0);
    end
    check("ovr_drained", 32'(mValid), 32'd0);
    repeat (BIT_CLKS) @(negedge clk);

    // Break: line low for longer than a whole frame, then released
    setLine(0, 1'b0);
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("brk_busy_held", 32'(busy),   32'd1);
    check("brk_valid",     32'(mValid), 32'd1);
    setLine(0, 1'b1);
    repeat (40) @(negedge clk);
    check("brk_busy_released", 32'(busy), 32'd0);
    check("brk_data", 32'(mData), 32'h00);
    check("brk_ferr", 32'(mFerr), 32'd1);
    check("brk_perr", 32'(mPerr), 32'd0);
    popHead(0);
    check("brk_one_entry", 32'(mValid), 32'd0);
    repeat (BIT_CLKS) @(negedge clk);
    sendFrame(0, 8'h55, 1'b0, 1'b0);
    waitBusyFall(0, "post_brk");
    repeat (2) @(negedge clk);
    check("post_brk_valid", 32'(mValid), 32'd1);
    check("post_brk_data",  32'(mData),  32'h55);
    check("post_brk_ferr",  32'(mFerr),  32'd0);
    popHead(0);
    repeat (BIT_CLKS) @(negedge clk);

    // False start: a three-tick low pulse while idle
    setLine(0, 1'b0);
    repeat (30) @(negedge clk);
    setLine(0, 1'b1);
    repeat (10) @(negedge clk);
    check("fs_busy_detect", 32'(busy), 32'd1);
    repeat (200) @(negedge clk);
    check("fs_busy_back", 32'(busy),   32'd0);
    check("fs_no_push",   32'(mValid), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    // One-tick low glitch around the decision of data bit 3 of 0xFF
    driveBit(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        setLine(0, 1'b1);
        repeat (78) @(negedge clk);
        setLine(0, 1'b0);
        repeat (10) @(negedge clk);
        setLine(0, 1'b1);
        repeat (BIT_CLKS - 88) @(negedge clk);
      end else begin
        driveBit(0, 1'b1);
      end
    end
    setLine(0, 1'b1);
    waitBusyFall(0, "glitch");
    repeat (2) @(negedge clk);
    check("glitch_data", 32'(mData), 32'hFF);
    popHead(0);
    repeat (BIT_CLKS) @(negedge clk);
`endif

    // Reset mid-frame with two entries queued
    sendFrame(0, 8'h21, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    sendFrame(0, 8'h22, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("rstmid_queued", 32'(mValid), 32'd1);
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    setLine(0, 1'b1);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(mValid), 32'd0);
    check("rstmid_busy",  32'(busy),   32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("rstmid_no_residue", 32'(mValid), 32'd0);
    sendFrame(0, 8'h3C, 1'b0, 1'b0);
    waitBusyFall(0, "post_rst");
    repeat (2) @(negedge clk);
    check("post_rst_valid", 32'(mValid), 32'd1);
    check("post_rst_data",  32'(mData),  32'h3C);
    check("post_rst_ferr",  32'(mFerr),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
